// File: rtl/lut_factorial_seq.sv
// Sequential n! / falling-factorial engine: one factor per pass, each pass an
// iterative shift-add multiply consuming MUL_BITS of the factor per cycle.
module lut_factorial_seq #(
   parameter int N_W      = 32,
   parameter int RES_W    = 64,
   parameter int MUL_BITS = 8
) (
   input  logic             clk_32b,
   input  logic             resetn_32b,
   input  logic             start,
   input  logic             mode,
   input  logic [N_W-1:0]   n,
   input  logic [N_W-1:0]   k,
   output logic             busy,
   output logic             done,
   output logic [RES_W-1:0] result,
   output logic             overflow
);

   localparam int M   = N_W / MUL_BITS;
   localparam int I_W = (M > 1) ? $clog2(M) : 1;
   localparam int P_W = RES_W + N_W;

   typedef enum logic [1:0] {IDLE, CHECK, MUL, DONE} state_t;

   state_t             state, state_nx;
   logic [RES_W-1:0]   acc;
   logic [P_W-1:0]     partial, partial_nx;
   logic [N_W-1:0]     cnt, factor;
   logic [I_W-1:0]     idx;
   logic               ovf;
   logic               last_chunk;

   // One shift-add step: the product of the accumulator and one factor chunk,
   // placed at the chunk's bit offset and added into the running partial.
   function automatic logic [P_W-1:0] mul_step(
      input logic [P_W-1:0]      part,
      input logic [RES_W-1:0]    a,
      input logic [MUL_BITS-1:0] chunk,
      input logic [I_W-1:0]      pos
   );
      logic [RES_W+MUL_BITS-1:0] prod;
      prod = {{MUL_BITS{1'b0}}, a} * {{RES_W{1'b0}}, chunk};
      return part + (P_W'(prod) << (pos * MUL_BITS));
   endfunction

   assign last_chunk = (idx == I_W'(M - 1));
   assign partial_nx = mul_step(partial, acc, factor[idx*MUL_BITS +: MUL_BITS], idx);

   always_ff @(posedge clk_32b or negedge resetn_32b) begin
      if (!resetn_32b) state <= IDLE;
      else             state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = CHECK;
         CHECK: begin
            busy = 1'b1;
            if (cnt == '0)              state_nx = DONE;
            else if (factor >= N_W'(2)) state_nx = MUL;
         end
         MUL: begin
            busy = 1'b1;
            if (last_chunk) state_nx = CHECK;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_32b or negedge resetn_32b) begin
      if (!resetn_32b) begin
         acc      <= '0;
         partial  <= '0;
         cnt      <= '0;
         factor   <= '0;
         idx      <= '0;
         ovf      <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               factor <= n;
               ovf    <= 1'b0;
               // k > n means the product passes through the factor 0
               if (mode && (k > n)) begin
                  acc <= '0;
                  cnt <= '0;
               end else begin
                  acc <= RES_W'(1);
                  cnt <= mode ? k : n;
               end
            end
            CHECK: begin
               if (cnt == '0) begin
                  result   <= acc;
                  overflow <= ovf;
               end else if (factor < N_W'(2)) begin
                  factor <= factor - 1'b1;
                  cnt    <= cnt - 1'b1;
               end else begin
                  partial <= '0;
                  idx     <= '0;
               end
            end
            MUL: begin
               partial <= partial_nx;
               idx     <= idx + 1'b1;
               if (last_chunk) begin
                  acc    <= partial_nx[RES_W-1:0];
                  ovf    <= ovf | (|partial_nx[P_W-1:RES_W]);
                  factor <= factor - 1'b1;
                  cnt    <= cnt - 1'b1;
                  idx    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lut_factorial_seq.sv
// Directed bench for lut_factorial_seq: default config plus two narrow configs
// (16/32 bits with 4-bit and 1-bit multiply chunks).
module tb_lut_factorial_seq;

   logic        clk_32b = 1'b0;
   logic        resetn_32b = 1'b0;
   logic        start_a [3];
   logic        mode_a  [3];
   logic [31:0] n_a     [3];
   logic [31:0] k_a     [3];
   logic        busy_a  [3];
   logic        done_a  [3];
   logic        ovf_a   [3];
   logic [63:0] res_a   [3];
   logic [63:0] res0;
   logic [31:0] res1, res2;

   int vecs = 0;
   int errs = 0;
   int lat, bcnt;

   always #5 clk_32b = ~clk_32b;

   lut_factorial_seq dut0 (
      .clk_32b(clk_32b), .resetn_32b(resetn_32b), .start(start_a[0]), .mode(mode_a[0]),
      .n(n_a[0]), .k(k_a[0]), .busy(busy_a[0]), .done(done_a[0]), .result(res0),
      .overflow(ovf_a[0]));

   lut_factorial_seq #(.N_W(16), .RES_W(32), .MUL_BITS(4)) dut1 (
      .clk_32b(clk_32b), .resetn_32b(resetn_32b), .start(start_a[1]), .mode(mode_a[1]),
      .n(n_a[1][15:0]), .k(k_a[1][15:0]), .busy(busy_a[1]), .done(done_a[1]), .result(res1),
      .overflow(ovf_a[1]));

   lut_factorial_seq #(.N_W(16), .RES_W(32), .MUL_BITS(1)) dut2 (
      .clk_32b(clk_32b), .resetn_32b(resetn_32b), .start(start_a[2]), .mode(mode_a[2]),
      .n(n_a[2][15:0]), .k(k_a[2][15:0]), .busy(busy_a[2]), .done(done_a[2]), .result(res2),
      .overflow(ovf_a[2]));

   assign res_a[0] = res0;
   assign res_a[1] = {32'd0, res1};
   assign res_a[2] = {32'd0, res2};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives start for one edge; returns at the falling edge of the first busy cycle.
   task automatic launch(input int s, input logic m, input logic [31:0] nv, input logic [31:0] kv);
      @(negedge clk_32b);
      start_a[s] = 1'b1;
      mode_a[s]  = m;
      n_a[s]     = nv;
      k_a[s]     = kv;
      @(posedge clk_32b);
      @(negedge clk_32b);
      start_a[s] = 1'b0;
   endtask

   // Counts cycles from the first busy cycle until done; start drops at cycle poke_end.
   task automatic wait_done(input int s, input int poke_end, output int l, output int b);
      l = 0;
      b = 0;
      while (!done_a[s] && l < 3000) begin
         if (busy_a[s]) b++;
         @(negedge clk_32b);
         l++;
         if (l == poke_end) start_a[s] = 1'b0;
      end
   endtask

   task automatic run(input int s, input logic m, input logic [31:0] nv, input logic [31:0] kv,
                      input logic [63:0] exp_res, input logic exp_ovf, input int exp_l,
                      input string tag);
      launch(s, m, nv, kv);
      wait_done(s, 0, lat, bcnt);
      chk({tag, " result"},   res_a[s], exp_res);
      chk({tag, " overflow"}, 64'(ovf_a[s]), 64'(exp_ovf));
      chk({tag, " latency"},  64'(lat), 64'(exp_l));
      chk({tag, " busy_cnt"}, 64'(bcnt), 64'(exp_l));
      chk({tag, " busy_at_done"}, 64'(busy_a[s]), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_a[i] = 1'b0; mode_a[i] = 1'b0; n_a[i] = '0; k_a[i] = '0;
      end
      repeat (3) @(negedge clk_32b);
      chk("rst busy",     64'(busy_a[0]), 64'd0);
      chk("rst done",     64'(done_a[0]), 64'd0);
      chk("rst result",   res_a[0], 64'd0);
      chk("rst overflow", 64'(ovf_a[0]), 64'd0);
      resetn_32b = 1'b1;

      run(0, 1'b0, 5,  0, 64'd120, 1'b0, 22, "fact5");
      run(0, 1'b0, 20, 0, 64'd2432902008176640000, 1'b0, 97, "fact20");
      run(0, 1'b0, 21, 0, 64'd14197454024290336768, 1'b1, 102, "fact21");
      run(0, 1'b0, 0,  0, 64'd1, 1'b0, 1, "fact0");
      run(0, 1'b0, 1,  0, 64'd1, 1'b0, 2, "fact1");
      run(0, 1'b1, 10, 3, 64'd720, 1'b0, 16, "fall10_3");
      run(0, 1'b1, 3,  5, 64'd0, 1'b0, 1, "fall3_5");
      run(0, 1'b1, 9,  0, 64'd1, 1'b0, 1, "fall9_0");

      // start re-asserted with n=7 throughout the early busy cycles
      launch(0, 1'b0, 5, 0);
      start_a[0] = 1'b1;
      n_a[0]     = 7;
      wait_done(0, 5, lat, bcnt);
      chk("poke result",  res_a[0], 64'd120);
      chk("poke latency", 64'(lat), 64'd22);
      chk("poke busy_cnt", 64'(bcnt), 64'd22);

      // start held through DONE restarts with the operand present then
      launch(0, 1'b0, 3, 0);
      start_a[0] = 1'b1;
      wait_done(0, 0, lat, bcnt);
      chk("hold first result",  res_a[0], 64'd6);
      chk("hold first latency", 64'(lat), 64'd12);
      n_a[0] = 4;
      @(posedge clk_32b);
      @(negedge clk_32b);
      chk("hold idle busy", 64'(busy_a[0]), 64'd0);
      @(posedge clk_32b);
      @(negedge clk_32b);
      start_a[0] = 1'b0;
      chk("hold restart busy", 64'(busy_a[0]), 64'd1);
      wait_done(0, 0, lat, bcnt);
      chk("hold second result",  res_a[0], 64'd24);
      chk("hold second latency", 64'(lat), 64'd17);

      // asynchronous reset while in MUL
      launch(0, 1'b0, 12, 0);
      @(negedge clk_32b);
      @(negedge clk_32b);
      chk("mid busy before rst", 64'(busy_a[0]), 64'd1);
      #2 resetn_32b = 1'b0;
      #1;
      chk("mid rst busy",     64'(busy_a[0]), 64'd0);
      chk("mid rst done",     64'(done_a[0]), 64'd0);
      chk("mid rst result",   res_a[0], 64'd0);
      chk("mid rst overflow", 64'(ovf_a[0]), 64'd0);
      @(negedge clk_32b);
      resetn_32b = 1'b1;
      run(0, 1'b0, 4, 0, 64'd24, 1'b0, 17, "after_rst4");

      run(1, 1'b0, 12, 0, 64'd479001600,  1'b0, 57,  "m4 fact12");
      run(1, 1'b0, 13, 0, 64'd1932053504, 1'b1, 62,  "m4 fact13");
      run(2, 1'b0, 12, 0, 64'd479001600,  1'b0, 189, "m16 fact12");
      run(2, 1'b0, 13, 0, 64'd1932053504, 1'b1, 206, "m16 fact13");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
